// File: rtl/serdes_deserializer_pkg.sv
// Shared types and constants for the serial receive path.
package serdes_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } serdes_rx_state_e;

    // K28.5 in both running disparities, LSB transmitted first
    localparam logic [9:0] K28_5_RDM = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    localparam int DEFAULT_WIDTH      = 10;
    localparam int DEFAULT_LOSS_LIMIT = 4;

endpackage

// File: rtl/serdes_deserializer_if.sv
// Receive-side serial pair and deserialized word outputs.
// master: serial source / word consumer, slave: the deserializer.
interface serdes_deserializer_if
    import serdes_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             Rx0_p;
    logic             Rx0_n;
    logic [WIDTH-1:0] Rx0;
    logic             rx_valid;
    logic             rx_comma;
    logic             rx_locked;
    logic             rx_diff_err;
    logic             rx_realign;

    modport master (
        output Rx0_p, Rx0_n,
        input  Rx0, rx_valid, rx_comma, rx_locked, rx_diff_err, rx_realign
    );

    modport slave (
        input  Rx0_p, Rx0_n,
        output Rx0, rx_valid, rx_comma, rx_locked, rx_diff_err, rx_realign
    );

endinterface

// File: rtl/serdes_comma_detect.sv
// Combinational comma / anti-comma match on a WIDTH-bit window.
module serdes_comma_detect
    import serdes_pkg::*;
    #(
        parameter int               WIDTH = DEFAULT_WIDTH,
        parameter logic [WIDTH-1:0] COMMA = WIDTH'(K28_5_RDM)
    ) (
        input  logic [WIDTH-1:0] window_i,
        output logic             is_comma_o,
        output logic             is_anti_o
    );

    assign is_comma_o = (window_i == COMMA);
    assign is_anti_o  = (window_i == ~COMMA);

endmodule

// File: rtl/serdes_deserializer.sv
// Serial-to-parallel receiver: hunts for a comma, then tracks word
// boundaries and drops lock after LOSS_LIMIT consecutive errored words.
module serdes_deserializer
    import serdes_pkg::*;
    #(
        parameter int               WIDTH      = DEFAULT_WIDTH,
        parameter logic [WIDTH-1:0] COMMA      = WIDTH'(K28_5_RDM),
        parameter int               LOSS_LIMIT = DEFAULT_LOSS_LIMIT
    ) (
        input  logic                 serial_clk,
        input  logic                 serdes_reset,
        serdes_deserializer_if.slave rx
    );

    localparam int CNT_W = $clog2(WIDTH);
    localparam int ERR_W = $clog2(LOSS_LIMIT + 1);

    serdes_rx_state_e  state_q;
    logic [WIDTH-1:0]  sr_q;
    logic [WIDTH-1:0]  sr_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [ERR_W-1:0]  err_cnt_inc;
    logic              word_err_q;
    logic              bit_err;
    logic              cur_err;
    logic              boundary;
    logic              is_comma;
    logic              is_anti;
    logic              any_comma;

    logic [WIDTH-1:0]  rx0_q;
    logic              rx_valid_q;
    logic              rx_comma_q;
    logic              rx_locked_q;
    logic              rx_diff_err_q;
    logic              rx_realign_q;

    serdes_comma_detect #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_comma_detect (
        .window_i   (sr_d),
        .is_comma_o (is_comma),
        .is_anti_o  (is_anti)
    );

    // Next window, per-bit error and boundary/saturation helpers
    always_comb begin
        sr_d        = {rx.Rx0_p, sr_q[WIDTH-1:1]};
        bit_err     = (rx.Rx0_p == rx.Rx0_n);
        cur_err     = word_err_q | bit_err;
        boundary    = (bit_cnt_q == CNT_W'(WIDTH - 1));
        any_comma   = is_comma | is_anti;
        err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    end

    // Alignment FSM with registered outputs
    always_ff @(posedge serial_clk or posedge serdes_reset) begin
        if (serdes_reset) begin
            state_q       <= HUNT;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            err_cnt_q     <= '0;
            word_err_q    <= 1'b0;
            rx0_q         <= '0;
            rx_valid_q    <= 1'b0;
            rx_comma_q    <= 1'b0;
            rx_locked_q   <= 1'b0;
            rx_diff_err_q <= 1'b0;
            rx_realign_q  <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            rx_diff_err_q <= bit_err;
            rx_valid_q    <= 1'b0;
            rx_comma_q    <= 1'b0;
            rx_realign_q  <= 1'b0;
            case (state_q)
                HUNT: begin
                    word_err_q  <= 1'b0;
                    rx_locked_q <= 1'b0;
                    if (any_comma) begin
                        rx0_q       <= sr_d;
                        rx_valid_q  <= 1'b1;
                        rx_comma_q  <= 1'b1;
                        bit_cnt_q   <= '0;
                        err_cnt_q   <= '0;
                        rx_locked_q <= 1'b1;
                        state_q     <= LOCKED;
                    end
                end
                LOCKED: begin
                    rx_locked_q <= 1'b1;
                    word_err_q  <= cur_err;
                    bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
                    if (boundary) begin
                        rx0_q      <= sr_d;
                        rx_valid_q <= 1'b1;
                        rx_comma_q <= any_comma;
                        bit_cnt_q  <= '0;
                        word_err_q <= 1'b0;
                        if (cur_err) begin
                            err_cnt_q <= err_cnt_inc;
                            if (err_cnt_inc >= ERR_W'(LOSS_LIMIT)) begin
                                state_q     <= HUNT;
                                rx_locked_q <= 1'b0;
                            end
                        end else begin
                            err_cnt_q <= '0;
                        end
                    end else if (any_comma) begin
                        // comma off the tracked boundary: re-anchor on it
                        rx0_q        <= sr_d;
                        rx_valid_q   <= 1'b1;
                        rx_comma_q   <= 1'b1;
                        rx_realign_q <= 1'b1;
                        bit_cnt_q    <= '0;
                        word_err_q   <= 1'b0;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign rx.Rx0         = rx0_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.rx_comma    = rx_comma_q;
    assign rx.rx_locked   = rx_locked_q;
    assign rx.rx_diff_err = rx_diff_err_q;
    assign rx.rx_realign  = rx_realign_q;

endmodule

// File: tb/tb_serdes_deserializer.sv
// Self-checking bench for serdes_deserializer.
module tb_serdes_deserializer;

    localparam logic [9:0] K_RDM = 10'h17C;
    localparam logic [9:0] K_RDP = 10'h283;
    localparam logic [9:0] D155  = 10'h155;

    logic serial_clk;
    logic serdes_reset;

    serdes_deserializer_if #(.WIDTH(10)) rx_if ();

    serdes_deserializer #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOSS_LIMIT (4)
    ) dut (
        .serial_clk   (serial_clk),
        .serdes_reset (serdes_reset),
        .rx           (rx_if)
    );

    initial serial_clk = 1'b0;
    always #5 serial_clk = ~serial_clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc;
    int         nvalid;
    int         ndiff;
    int         nrealign;
    logic [9:0] cap_word;
    logic       cap_comma;
    logic       cap_realign;
    logic       cap_locked;
    int         cap_cyc;

    task automatic clear_counts();
        nvalid   = 0;
        ndiff    = 0;
        nrealign = 0;
        cap_word = '0;
        cap_cyc  = 0;
    endtask

    // Drive one bit, let it be sampled, observe outputs 1 ns after the edge
    task automatic tick(input logic b, input logic bad);
        rx_if.Rx0_p = b;
        rx_if.Rx0_n = bad ? b : ~b;
        @(posedge serial_clk);
        #1;
        cyc++;
        if (rx_if.rx_valid) begin
            nvalid++;
            cap_word    = rx_if.Rx0;
            cap_comma   = rx_if.rx_comma;
            cap_realign = rx_if.rx_realign;
            cap_locked  = rx_if.rx_locked;
            cap_cyc     = cyc;
        end
        if (rx_if.rx_diff_err) ndiff++;
        if (rx_if.rx_realign)  nrealign++;
    endtask

    task automatic send_word(input logic [9:0] w, input int err_bit);
        for (int i = 0; i < 10; i++) tick(w[i], i == err_bit);
    endtask

    task automatic do_reset();
        serdes_reset = 1'b1;
        rx_if.Rx0_p  = 1'b0;
        rx_if.Rx0_n  = 1'b1;
        repeat (2) @(posedge serial_clk);
        @(negedge serial_clk);
        serdes_reset = 1'b0;
        @(posedge serial_clk);
        #1;
        cyc = 0;
        clear_counts();
    endtask

    // True if appending cand after prev would put a comma in any window
    // ending inside cand (including cand itself).
    function automatic bit makes_comma(input logic [9:0] prev, input logic [9:0] cand);
        logic [19:0] cat;
        logic [9:0]  w;
        cat = {cand, prev};
        for (int k = 1; k <= 10; k++) begin
            w = cat[k +: 10];
            if (w == K_RDM || w == K_RDP) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        serdes_reset = 1'b1;
        #1;
        n_checks++;
        if (rx_if.Rx0 !== 10'h0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_comma !== 1'b0 ||
            rx_if.rx_locked !== 1'b0 || rx_if.rx_diff_err !== 1'b0 || rx_if.rx_realign !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: Rx0=%h valid=%b comma=%b locked=%b diff=%b realign=%b, required all 0",
                     rx_if.Rx0, rx_if.rx_valid, rx_if.rx_comma, rx_if.rx_locked, rx_if.rx_diff_err, rx_if.rx_realign);
        end
        do_reset();
        repeat (30) tick(1'b0, 1'b0);
        n_checks++;
        if (nvalid !== 0) begin
            n_fail++;
            $display("FAIL idle_valid: got %0d valid pulses, required 0", nvalid);
        end
        n_checks++;
        if (rx_if.rx_locked !== 1'b0 || rx_if.Rx0 !== 10'h0) begin
            n_fail++;
            $display("FAIL idle_state: locked=%b Rx0=%h, required 0/000", rx_if.rx_locked, rx_if.Rx0);
        end
    endtask

    task automatic test_comma_lock();
        int first_cyc;
        send_word(K_RDM, -1);
        n_checks++;
        if (nvalid !== 1 || cap_cyc !== cyc) begin
            n_fail++;
            $display("FAIL comma_latency: valid count %0d at cycle %0d, required 1 at cycle %0d", nvalid, cap_cyc, cyc);
        end
        n_checks++;
        if (cap_word !== K_RDM || cap_comma !== 1'b1 || cap_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL comma_capture: Rx0=%h comma=%b locked=%b, required 17c/1/1", cap_word, cap_comma, cap_locked);
        end
        first_cyc = cap_cyc;
        send_word(D155, -1);
        n_checks++;
        if (nvalid !== 2 || cap_cyc - first_cyc !== 10) begin
            n_fail++;
            $display("FAIL data_spacing: valid count %0d spacing %0d, required 2 / 10", nvalid, cap_cyc - first_cyc);
        end
        n_checks++;
        if (cap_word !== D155 || cap_comma !== 1'b0) begin
            n_fail++;
            $display("FAIL data_capture: Rx0=%h comma=%b, required 155/0", cap_word, cap_comma);
        end
    endtask

    task automatic test_realign();
        int rcyc;
        clear_counts();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        send_word(K_RDP, -1);
        n_checks++;
        if (nrealign !== 1 || cap_realign !== 1'b1 || cap_cyc !== cyc) begin
            n_fail++;
            $display("FAIL realign_pulse: count %0d flag %b, required 1/1 on last comma bit", nrealign, cap_realign);
        end
        n_checks++;
        if (cap_word !== K_RDP || cap_comma !== 1'b1 || cap_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL realign_capture: Rx0=%h comma=%b locked=%b, required 283/1/1", cap_word, cap_comma, cap_locked);
        end
        rcyc = cap_cyc;
        send_word(D155, -1);
        n_checks++;
        if (cap_word !== D155 || cap_cyc - rcyc !== 10 || cap_realign !== 1'b0 || nrealign !== 1) begin
            n_fail++;
            $display("FAIL realign_follow: Rx0=%h spacing %0d realign=%b, required 155/10/0", cap_word, cap_cyc - rcyc, cap_realign);
        end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        send_word(K_RDM, -1);
        clear_counts();
        for (int w = 0; w < 3; w++) send_word(D155, 3);
        n_checks++;
        if (cap_locked !== 1'b1 || nvalid !== 3) begin
            n_fail++;
            $display("FAIL loss_three: locked=%b valid count %0d, required 1/3", cap_locked, nvalid);
        end
        send_word(D155, 3);
        n_checks++;
        if (ndiff !== 4) begin
            n_fail++;
            $display("FAIL loss_diff_pulses: got %0d, required 4", ndiff);
        end
        n_checks++;
        if (nvalid !== 4 || cap_word !== D155 || cap_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_drop: valid count %0d Rx0=%h locked=%b, required 4/155/0", nvalid, cap_word, cap_locked);
        end

        do_reset();
        send_word(K_RDM, -1);
        clear_counts();
        for (int w = 0; w < 3; w++) send_word(D155, 3);
        send_word(D155, -1);
        for (int w = 0; w < 3; w++) send_word(D155, 3);
        n_checks++;
        if (cap_locked !== 1'b1 || rx_if.rx_locked !== 1'b1 || ndiff !== 6) begin
            n_fail++;
            $display("FAIL loss_recover: locked=%b diff count %0d, required 1/6", cap_locked, ndiff);
        end
        send_word(D155, 3);
        n_checks++;
        if (cap_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_after_recover: locked=%b, required 0", cap_locked);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_word(K_RDM, -1);
        for (int i = 0; i < 5; i++) tick(D155[i], 1'b0);
        #2;
        serdes_reset = 1'b1;
        #1;
        n_checks++;
        if (rx_if.Rx0 !== 10'h0 || rx_if.rx_valid !== 1'b0 || rx_if.rx_comma !== 1'b0 ||
            rx_if.rx_locked !== 1'b0 || rx_if.rx_diff_err !== 1'b0 || rx_if.rx_realign !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: Rx0=%h valid=%b locked=%b, required all 0",
                     rx_if.Rx0, rx_if.rx_valid, rx_if.rx_locked);
        end
        @(negedge serial_clk);
        serdes_reset = 1'b0;
        @(posedge serial_clk);
        #1;
        clear_counts();
        for (int i = 5; i < 10; i++) tick(D155[i], 1'b0);
        for (int w = 0; w < 3; w++) send_word(D155, -1);
        n_checks++;
        if (nvalid !== 0 || rx_if.rx_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: valid count %0d locked=%b, required 0/0", nvalid, rx_if.rx_locked);
        end
        send_word(K_RDM, -1);
        n_checks++;
        if (nvalid !== 1 || cap_word !== K_RDM) begin
            n_fail++;
            $display("FAIL post_reset_relock: valid count %0d Rx0=%h, required 1/17c", nvalid, cap_word);
        end
    endtask

    task automatic test_random_stream();
        logic [9:0] prev;
        logic [9:0] w;
        int         last_cyc;
        int         exp_valid;
        do_reset();
        send_word(K_RDM, -1);
        prev      = K_RDM;
        last_cyc  = cap_cyc;
        exp_valid = 1;
        for (int n = 0; n < 50; n++) begin
            w = 10'($urandom_range(0, 1023));
            while (makes_comma(prev, w)) w = 10'($urandom_range(0, 1023));
            send_word(w, -1);
            exp_valid++;
            n_checks++;
            if (nvalid !== exp_valid || cap_word !== w || cap_comma !== 1'b0) begin
                n_fail++;
                $display("FAIL random_word[%0d]: Rx0=%h comma=%b valid count %0d, required %h/0/%0d",
                         n, cap_word, cap_comma, nvalid, w, exp_valid);
            end
            n_checks++;
            if (cap_cyc - last_cyc !== 10) begin
                n_fail++;
                $display("FAIL random_spacing[%0d]: got %0d cycles, required 10", n, cap_cyc - last_cyc);
            end
            last_cyc = cap_cyc;
            prev     = w;
        end
        n_checks++;
        if (rx_if.rx_locked !== 1'b1 || nrealign !== 0) begin
            n_fail++;
            $display("FAIL random_lock: locked=%b realign count %0d, required 1/0", rx_if.rx_locked, nrealign);
        end
    endtask

    initial begin
        serdes_reset = 1'b1;
        rx_if.Rx0_p  = 1'b0;
        rx_if.Rx0_n  = 1'b1;
        cyc          = 0;
        clear_counts();
        test_reset();
        test_comma_lock();
        test_realign();
        test_loss_of_lock();
        test_async_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
